// File: rtl/config_sram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : config_sram_loader                                           |
// | Description : Accepts one address/data word on a valid/ready handshake,    |
// |               shifts it MSB-first (data then address) onto the config      |
// |               chain, then issues a one-cycle config_set commit strobe      |
// |               followed by a one-cycle done pulse.                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module config_sram_loader #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 cclk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_BITS-1:0] in_address,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 shift_out,
  output logic                 shift_enable,
  output logic                 config_set,
  output logic                 busy,
  output logic                 done
);

  localparam int c_TOTAL = ADDR_BITS + DATA_BITS;
  localparam int c_CNT_W = $clog2(c_TOTAL + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(c_TOTAL);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_SET   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_TOTAL-1:0]   r_sreg;
  logic [c_TOTAL-1:0]   w_sreg_next;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_next;

  logic r_in_ready, r_shift_out, r_shift_enable, r_config_set, r_busy, r_done;
  logic w_in_ready, w_shift_out, w_shift_enable, w_config_set, w_busy, w_done;

  // State register; reset abandons any word in flight.
  always_ff @(posedge cclk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, datapath update and next output values. Outputs are decoded
  // from the next state so that the registered copies line up with the state.
  always_comb begin
    w_state_next = r_state;
    w_sreg_next  = r_sreg;
    w_cnt_next   = r_cnt;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_sreg_next  = {in_data, in_address};
          w_cnt_next   = c_CNT_LOAD;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_sreg_next = {r_sreg[c_TOTAL-2:0], 1'b0};
        w_cnt_next  = r_cnt - c_CNT_ONE;
        if (r_cnt == c_CNT_ONE) begin
          w_state_next = S_SET;
        end
      end
      S_SET: begin
        w_state_next = S_DONE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    w_in_ready     = (w_state_next == S_IDLE);
    w_shift_enable = (w_state_next == S_SHIFT);
    w_shift_out    = w_shift_enable & w_sreg_next[c_TOTAL-1];
    w_config_set   = (w_state_next == S_SET);
    w_busy         = (w_state_next == S_SHIFT) || (w_state_next == S_SET);
    w_done         = (w_state_next == S_DONE);
  end

  // Shift register, bit counter and registered outputs.
  always_ff @(posedge cclk) begin
    if (rst) begin
      r_sreg         <= '0;
      r_cnt          <= '0;
      r_in_ready     <= 1'b1;
      r_shift_out    <= 1'b0;
      r_shift_enable <= 1'b0;
      r_config_set   <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_sreg         <= w_sreg_next;
      r_cnt          <= w_cnt_next;
      r_in_ready     <= w_in_ready;
      r_shift_out    <= w_shift_out;
      r_shift_enable <= w_shift_enable;
      r_config_set   <= w_config_set;
      r_busy         <= w_busy;
      r_done         <= w_done;
    end
  end

  assign in_ready     = r_in_ready;
  assign shift_out    = r_shift_out;
  assign shift_enable = r_shift_enable;
  assign config_set   = r_config_set;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_config_sram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_config_sram_loader                                        |
// | Description : Directed self-checking bench for config_sram_loader with a   |
// |               small chain receiver model and a parameter sweep.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_config_sram_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_address = '0;
  logic [7:0] in_data = '0;
  logic       shift_out, shift_enable, config_set, busy, done;

  logic [2:0] sw_valid = '0;
  logic [2:0] sw_ready, sw_so, sw_se, sw_cs, sw_busy, sw_done;
  logic [9:0]  sw_addr [3];
  logic [31:0] sw_data [3];

  int cyc = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Edge counter used to measure acceptance spacing.
  always @(posedge clk) cyc <= cyc + 1;

  config_sram_loader #(.ADDR_BITS(8), .DATA_BITS(8)) u_dut (
    .cclk         (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_address   (in_address),
    .in_data      (in_data),
    .shift_out    (shift_out),
    .shift_enable (shift_enable),
    .config_set   (config_set),
    .busy         (busy),
    .done         (done)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int A = (g == 0) ? 1 : (g == 1) ? 4 : 10;
    localparam int D = (g == 0) ? 1 : (g == 1) ? 12 : 32;
    config_sram_loader #(.ADDR_BITS(A), .DATA_BITS(D)) u_dut (
      .cclk         (clk),
      .rst          (rst),
      .in_valid     (sw_valid[g]),
      .in_ready     (sw_ready[g]),
      .in_address   (sw_addr[g][A-1:0]),
      .in_data      (sw_data[g][D-1:0]),
      .shift_out    (sw_so[g]),
      .shift_enable (sw_se[g]),
      .config_set   (sw_cs[g]),
      .busy         (sw_busy[g]),
      .done         (sw_done[g])
    );
  end

  // {in_ready, shift_out, shift_enable, config_set, busy, done}
  function automatic logic [5:0] ovec();
    return {in_ready, shift_out, shift_enable, config_set, busy, done};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction on the 8/8 loader, entered and left on a negedge.
  // The chain receiver is modelled by shifting in shift_out on every
  // shift_enable cycle; after 16 shifts it holds {data, address}.
  task automatic do_word(input logic [7:0] a, input logic [7:0] d, input bit keep,
                         input bit scr, input string tag, output int t_acc);
    logic [15:0] word;
    logic [15:0] rx;
    word = {d, a};
    rx = '0;
    in_address = a;
    in_data = d;
    in_valid = 1'b1;
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    t_acc = cyc;
    if (!keep) in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk({tag, "_shift"}, 64'(ovec()), 64'({1'b0, word[15-k], 4'b1010}));
      if (shift_enable) rx = {rx[14:0], shift_out};
      if (scr) begin
        in_address = 8'($urandom);
        in_data = 8'($urandom);
      end
      @(negedge clk);
    end
    chk({tag, "_set"}, 64'(ovec()), 64'(6'b000110));
    chk({tag, "_waddr"}, 64'(rx[7:0]), 64'(a));
    chk({tag, "_wdata"}, 64'(rx[15:8]), 64'(d));
    @(negedge clk);
    chk({tag, "_done"}, 64'(ovec()), 64'(6'b000001));
    @(negedge clk);
    chk({tag, "_idle"}, 64'(in_ready), 64'd1);
  endtask

  // One random word on a sweep instance; counts shift cycles and rebuilds
  // the stream until config_set, with a cycle bound.
  task automatic sweep(input int idx, input int a_bits, input int d_bits);
    logic [9:0]  a;
    logic [31:0] d;
    logic [41:0] word;
    logic [41:0] rx;
    int n_se;
    bit got_cs;
    a = 10'($urandom) & ((10'd1 << a_bits) - 10'd1);
    d = 32'($urandom) & ((32'd1 << d_bits) - 32'd1);
    word = (42'(d) << a_bits) | 42'(a);
    rx = '0;
    n_se = 0;
    got_cs = 1'b0;
    sw_addr[idx] = a;
    sw_data[idx] = d;
    sw_valid[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sw_valid[idx] = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (sw_cs[idx]) begin
        got_cs = 1'b1;
        break;
      end
      if (sw_se[idx]) begin
        rx = {rx[40:0], sw_so[idx]};
        n_se++;
      end
      @(negedge clk);
    end
    chk($sformatf("sweep%0d_cs", idx), 64'(got_cs), 64'd1);
    chk($sformatf("sweep%0d_nse", idx), 64'(n_se), 64'(a_bits + d_bits));
    chk($sformatf("sweep%0d_word", idx), 64'(rx), 64'(word));
    repeat (3) @(negedge clk);
    chk($sformatf("sweep%0d_idle", idx), 64'(sw_ready[idx]), 64'd1);
  endtask

  initial begin
    int t1, t2, t3;
    for (int i = 0; i < 3; i++) begin
      sw_addr[i] = '0;
      sw_data[i] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_state", 64'(ovec()), 64'(6'b100000));
    rst = 1'b0;

    // Idle stability
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_stable", 64'(ovec()), 64'(6'b100000));
    end

    // Single word: stream 0011_1100_1010_0101
    do_word(8'hA5, 8'h3C, 1'b0, 1'b0, "single", t1);

    // Back-to-back with in_valid held high
    @(negedge clk);
    do_word(8'h01, 8'hFF, 1'b1, 1'b0, "b2b_a", t1);
    do_word(8'hFE, 8'h00, 1'b0, 1'b0, "b2b_b", t2);
    chk("b2b_spacing", 64'(t2 - t1), 64'd19);

    // Inputs scrambled during shifting
    @(negedge clk);
    do_word(8'h6B, 8'hD2, 1'b0, 1'b1, "scramble", t3);

    // Reset during the 7th shift cycle
    @(negedge clk);
    in_address = 8'h12;
    in_data = 8'h34;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_pre", 64'(shift_enable), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid", 64'(ovec()), 64'(6'b100000));
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk("rst_quiet", 64'(ovec()), 64'(6'b100000));
    end
    do_word(8'h55, 8'hAA, 1'b0, 1'b0, "post_rst", t3);

    // Parameter sweep
    @(negedge clk);
    sweep(0, 1, 1);
    sweep(1, 4, 12);
    sweep(2, 10, 32);
    sweep(2, 10, 32);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
